// File: rtl/conv_window_gen.sv
// conv_window_gen: parametrised KxK sliding-window generator.
//
// Takes a raster-order pixel stream and presents a full KxK window for every output
// position selected by STRIDE. The pixels pass through a (K-1)*IMG_W+K deep shift
// register, and each window slot is read from a fixed tap in that register.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   i_data/i_valid    input pixel and its valid
//   i_ready           pixel can be accepted this cycle
//   o_win             K*K pixels; slot r*K+c = pixel (o_row+r, o_col+c)
//   o_valid/o_ready   window handshake
//   o_row/o_col       top-left position of the presented window
//   o_last            (CONV_WINDOW_GEN_LAST_EN only) final window of the frame
//
// Optional feature macro: CONV_WINDOW_GEN_LAST_EN adds the o_last output.

module conv_window_gen #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned IMG_W      = 7,
   parameter int unsigned IMG_H      = 7,
   parameter int unsigned K          = 3,
   parameter int unsigned STRIDE     = 1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [DATA_WIDTH-1:0]          i_data,
   input  logic                           i_valid,
   output logic                           i_ready,
   output logic [K*K*DATA_WIDTH-1:0]      o_win,
   output logic                           o_valid,
   input  logic                           o_ready,
   output logic [15:0]                    o_row,
   output logic [15:0]                    o_col
`ifdef CONV_WINDOW_GEN_LAST_EN
   ,
   output logic                           o_last
`endif
);

   localparam int unsigned DEPTH = (K - 1) * IMG_W + K;
   localparam int unsigned CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int unsigned RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;

   logic [DATA_WIDTH-1:0] sr_q [DEPTH];
   logic [CW-1:0]         col_q, col_d;
   logic [RW-1:0]         row_q, row_d;
   logic                  accept;
   logic                  qualify;
   logic                  col_wrap, row_wrap;
   logic [15:0]           row_off, col_off;

   assign i_ready = !o_valid || o_ready;
   assign accept  = i_valid && i_ready;

   // Offsets wrap for positions above/left of the first window; the range gate masks them.
   assign row_off = 16'(row_q) - 16'(K - 1);
   assign col_off = 16'(col_q) - 16'(K - 1);

   assign qualify = (16'(row_q) >= 16'(K - 1)) && (16'(col_q) >= 16'(K - 1)) &&
                    ((row_off % 16'(STRIDE)) == 16'd0) &&
                    ((col_off % 16'(STRIDE)) == 16'd0);

`ifdef CONV_WINDOW_GEN_LAST_EN
   localparam int unsigned LAST_ROW0 = ((IMG_H - K) / STRIDE) * STRIDE;
   localparam int unsigned LAST_COL0 = ((IMG_W - K) / STRIDE) * STRIDE;

   logic is_last;
   assign is_last = (row_off == 16'(LAST_ROW0)) && (col_off == 16'(LAST_COL0));
`endif

   assign col_wrap = (col_q == CW'(IMG_W - 1));
   assign row_wrap = (row_q == RW'(IMG_H - 1));

   // Position of the next pixel; wraps straight into the next frame.
   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (accept) begin
         if (col_wrap) begin
            col_d = '0;
            row_d = row_wrap ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            sr_q[i] <= '0;
         end
      end else if (accept) begin
         sr_q[0] <= i_data;
         for (int unsigned i = 1; i < DEPTH; i++) begin
            sr_q[i] <= sr_q[i-1];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_q   <= '0;
         col_q   <= '0;
         o_valid <= 1'b0;
         o_row   <= '0;
         o_col   <= '0;
`ifdef CONV_WINDOW_GEN_LAST_EN
         o_last  <= 1'b0;
`endif
      end else begin
         row_q <= row_d;
         col_q <= col_d;
         // A qualifying accept wins over a same-edge handshake so no window is lost.
         if (accept && qualify) begin
            o_valid <= 1'b1;
            o_row   <= row_off;
            o_col   <= col_off;
`ifdef CONV_WINDOW_GEN_LAST_EN
            o_last  <= is_last;
`endif
         end else if (o_ready) begin
            o_valid <= 1'b0;
         end
      end
   end

   // Entry 0 holds the bottom-right pixel once the window's last pixel has been accepted.
   for (genvar r = 0; r < K; r++) begin : g_row
      for (genvar c = 0; c < K; c++) begin : g_col
         assign o_win[(r*K+c)*DATA_WIDTH +: DATA_WIDTH] = sr_q[(K-1-r)*IMG_W + (K-1-c)];
      end
   end

endmodule
